// File: rtl/irrigation_pump_sequencer.sv
// -----------------------------------------------------------------------------
// irrigation_pump_sequencer
//
// Takes a run request from the fuzzy irrigation engine. On an accepted start it
// latches the requested duration (clamped to MAX_UNITS) and drives the pump for
// exactly that many time units. Rain or a manual stop aborts the run. Every run
// is followed by a forced pump-off cooldown before the next request is accepted.
// A saturating 16-bit total of fully watered units is kept until reset.
//
// Parameters
//   TICKS_PER_UNIT  clk cycles per time unit (>= 1)
//   COOLDOWN_UNITS  units of forced pump-off after each run (0 = none)
//   MAX_UNITS       upper clamp on the latched irrigation_time
//
// Ports
//   clk              in   system clock
//   reset            in   asynchronous active-low reset
//   start            in   run request, honoured only in IDLE
//   irrigation_time  in   [7:0] requested duration in units
//   rain_present     in   rain flag from the fuzzy engine
//   manual_stop      in   operator abort (level)
//   pump_on          out  pump/valve drive
//   busy             out  high in WATERING or COOLDOWN
//   remaining        out  [7:0] units left in the current run, else 0
//   done             out  one-cycle pulse, run completed normally
//   aborted          out  one-cycle pulse, run ended by rain or manual_stop
//   skipped          out  one-cycle pulse, start accepted with nothing to water
//   total_units      out  [15:0] saturating count of completed units
//   state            out  [1:0] current FSM state
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | pump off, waiting for start
// WATERING | pump on, counting down the latched number of units
// COOLDOWN | pump off, counting COOLDOWN_UNITS before start is honoured
// -----------------------------------------------------------------------------
module irrigation_pump_sequencer #(
    parameter int unsigned TICKS_PER_UNIT = 50_000_000,
    parameter int unsigned COOLDOWN_UNITS = 60,
    parameter logic [7:0]  MAX_UNITS      = 8'd200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  irrigation_time,
    input  logic        rain_present,
    input  logic        manual_stop,
    output logic        pump_on,
    output logic        busy,
    output logic [7:0]  remaining,
    output logic        done,
    output logic        aborted,
    output logic        skipped,
    output logic [15:0] total_units,
    output logic [1:0]  state
);

    localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int CW = (COOLDOWN_UNITS > 1) ? $clog2(COOLDOWN_UNITS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_UNIT - 1);
    localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN_UNITS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WATERING = 2'b01,
        ST_COOLDOWN = 2'b10
    } state_t;

    state_t         state_q, state_nx;
    logic [PW-1:0]  presc_q, presc_nx;
    logic [CW-1:0]  cool_q, cool_nx;
    logic [7:0]     remaining_nx;
    logic [15:0]    total_nx;
    logic           pump_nx, busy_nx, done_nx, aborted_nx, skipped_nx;

    logic           unit_tick;
    logic [7:0]     req_units;
    logic [PW-1:0]  presc_adv;

    assign unit_tick = (presc_q == PRESC_LAST);
    assign presc_adv = unit_tick ? '0 : presc_q + PW'(1);
    assign req_units = (irrigation_time > MAX_UNITS) ? MAX_UNITS : irrigation_time;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            cool_q      <= '0;
            remaining   <= '0;
            total_units <= '0;
            pump_on     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            skipped     <= 1'b0;
        end else begin
            state_q     <= state_nx;
            presc_q     <= presc_nx;
            cool_q      <= cool_nx;
            remaining   <= remaining_nx;
            total_units <= total_nx;
            pump_on     <= pump_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            aborted     <= aborted_nx;
            skipped     <= skipped_nx;
        end
    end

    always_comb begin
        state_nx     = state_q;
        presc_nx     = '0;
        cool_nx      = cool_q;
        remaining_nx = remaining;
        total_nx     = total_units;
        pump_nx      = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;
        aborted_nx   = 1'b0;
        skipped_nx   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (rain_present || manual_stop || (req_units == 8'd0)) begin
                        skipped_nx = 1'b1;
                    end else begin
                        state_nx     = ST_WATERING;
                        remaining_nx = req_units;
                        pump_nx      = 1'b1;
                        busy_nx      = 1'b1;
                    end
                end
            end

            ST_WATERING: begin
                pump_nx  = 1'b1;
                busy_nx  = 1'b1;
                presc_nx = presc_adv;
                // Abort is checked first so a coincident final tick is neither
                // counted nor reported as done.
                if (rain_present || manual_stop) begin
                    aborted_nx   = 1'b1;
                    remaining_nx = 8'd0;
                    pump_nx      = 1'b0;
                    presc_nx     = '0;
                end else if (unit_tick) begin
                    total_nx     = (total_units == 16'hFFFF) ? total_units
                                                             : total_units + 16'd1;
                    remaining_nx = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        done_nx = 1'b1;
                        pump_nx = 1'b0;
                    end
                end

                if (aborted_nx || done_nx) begin
                    if (COOLDOWN_UNITS == 0) begin
                        state_nx = ST_IDLE;
                        busy_nx  = 1'b0;
                    end else begin
                        state_nx = ST_COOLDOWN;
                        cool_nx  = COOL_LOAD;
                    end
                end
            end

            ST_COOLDOWN: begin
                busy_nx  = 1'b1;
                presc_nx = presc_adv;
                if (unit_tick) begin
                    if (cool_q == CW'(1)) begin
                        state_nx = ST_IDLE;
                        busy_nx  = 1'b0;
                        presc_nx = '0;
                    end else begin
                        cool_nx = cool_q - CW'(1);
                    end
                end
            end

            default: begin
                state_nx     = ST_IDLE;
                remaining_nx = 8'd0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_irrigation_pump_sequencer.sv
module tb_irrigation_pump_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  irrigation_time;
    logic        rain_present;
    logic        manual_stop;
    logic        pump_on;
    logic        busy;
    logic [7:0]  remaining;
    logic        done;
    logic        aborted;
    logic        skipped;
    logic [15:0] total_units;
    logic [1:0]  state;

    // second instance: one clk per unit, no cooldown, used for saturation
    logic        reset_b;
    logic        start_b;
    logic [7:0]  time_b;
    logic        rain_b;
    logic        mstop_b;
    logic        pump_on_b;
    logic        busy_b;
    logic [7:0]  remaining_b;
    logic        done_b;
    logic        aborted_b;
    logic        skipped_b;
    logic [15:0] total_b;
    logic [1:0]  state_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rem_log [0:1023];
    logic [1:0] st_log  [0:1023];
    int pump_cnt, busy_cnt, done_cnt, abort_cnt, skip_cnt, done_idx, abort_idx;

    irrigation_pump_sequencer #(
        .TICKS_PER_UNIT(4),
        .COOLDOWN_UNITS(2),
        .MAX_UNITS(8'd200)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .irrigation_time(irrigation_time), .rain_present(rain_present),
        .manual_stop(manual_stop), .pump_on(pump_on), .busy(busy),
        .remaining(remaining), .done(done), .aborted(aborted),
        .skipped(skipped), .total_units(total_units), .state(state)
    );

    irrigation_pump_sequencer #(
        .TICKS_PER_UNIT(1),
        .COOLDOWN_UNITS(0),
        .MAX_UNITS(8'd200)
    ) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .irrigation_time(time_b), .rain_present(rain_b),
        .manual_stop(mstop_b), .pump_on(pump_on_b), .busy(busy_b),
        .remaining(remaining_b), .done(done_b), .aborted(aborted_b),
        .skipped(skipped_b), .total_units(total_b), .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic apply_event(input int kind);
        case (kind)
            1: rain_present = 1'b1;
            2: manual_stop  = 1'b1;
            3: begin
                start           = 1'b1;
                irrigation_time = 8'd5;
            end
            default: ;
        endcase
    endtask

    // First edge consumed here is the one that samples a start set by the caller.
    task automatic watch(input int ncyc, input int e1_idx, input int e1_kind,
                         input int e2_idx, input int e2_kind);
        pump_cnt = 0; busy_cnt = 0; done_cnt = 0; abort_cnt = 0; skip_cnt = 0;
        done_idx = -1; abort_idx = -1;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            rem_log[i] = remaining;
            st_log[i]  = state;
            if (pump_on) pump_cnt++;
            if (busy)    busy_cnt++;
            if (skipped) skip_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (aborted) begin
                abort_cnt++;
                if (abort_idx < 0) abort_idx = i;
            end
            start = 1'b0;
            if (i == e1_idx) apply_event(e1_kind);
            if (i == e2_idx) apply_event(e2_kind);
        end
        rain_present = 1'b0;
        manual_stop  = 1'b0;
    endtask

    initial begin
        int exp_tot;
        int pc;
        bit got_end;

        reset = 1'b0; reset_b = 1'b0;
        start = 1'b0; irrigation_time = 8'd0; rain_present = 1'b0; manual_stop = 1'b0;
        start_b = 1'b0; time_b = 8'd0; rain_b = 1'b0; mstop_b = 1'b0;

        #12;
        check_eq("rst_pump",  32'(pump_on), 0);
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_total", 32'(total_units), 0);
        check_eq("rst_rem",   32'(remaining), 0);
        #20;
        reset = 1'b1; reset_b = 1'b1;
        @(posedge clk); #1;

        // 1: normal 3-unit run
        start = 1'b1; irrigation_time = 8'd3;
        watch(24, -1, 0, -1, 0);
        check_eq("t1_rem0",  32'(rem_log[0]), 3);
        check_eq("t1_rem4",  32'(rem_log[4]), 2);
        check_eq("t1_rem8",  32'(rem_log[8]), 1);
        check_eq("t1_rem12", 32'(rem_log[12]), 0);
        check_eq("t1_pump_cycles", 32'(pump_cnt), 12);
        check_eq("t1_done_cnt", 32'(done_cnt), 1);
        check_eq("t1_done_idx", 32'(done_idx), 12);
        check_eq("t1_busy_cycles", 32'(busy_cnt), 20);
        check_eq("t1_state_cool", 32'(st_log[12]), 2);
        check_eq("t1_state_idle", 32'(st_log[20]), 0);
        check_eq("t1_total", 32'(total_units), 3);

        // 2: skipped requests
        start = 1'b1; irrigation_time = 8'd0;
        @(posedge clk); #1;
        check_eq("t2a_skip", 32'(skipped), 1);
        check_eq("t2a_state", 32'(state), 0);
        check_eq("t2a_pump", 32'(pump_on), 0);
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("t2a_skip_pulse", 32'(skipped), 0);
        start = 1'b1; irrigation_time = 8'd10; rain_present = 1'b1;
        @(posedge clk); #1;
        check_eq("t2b_skip", 32'(skipped), 1);
        check_eq("t2b_state", 32'(state), 0);
        check_eq("t2b_busy", 32'(busy), 0);
        start = 1'b0; rain_present = 1'b0;
        start = 1'b1; irrigation_time = 8'd5; manual_stop = 1'b1;
        @(posedge clk); #1;
        check_eq("t2c_skip", 32'(skipped), 1);
        check_eq("t2c_pump", 32'(pump_on), 0);
        start = 1'b0; manual_stop = 1'b0;
        @(posedge clk); #1;

        // 3: rain abort after two full units
        start = 1'b1; irrigation_time = 8'd10;
        watch(20, 8, 1, -1, 0);
        check_eq("t3_rem8", 32'(rem_log[8]), 8);
        check_eq("t3_abort_idx", 32'(abort_idx), 9);
        check_eq("t3_abort_cnt", 32'(abort_cnt), 1);
        check_eq("t3_done_cnt", 32'(done_cnt), 0);
        check_eq("t3_pump_cycles", 32'(pump_cnt), 9);
        check_eq("t3_rem_after", 32'(rem_log[9]), 0);
        check_eq("t3_busy_cycles", 32'(busy_cnt), 17);
        check_eq("t3_state_idle", 32'(st_log[17]), 0);
        check_eq("t3_total", 32'(total_units), 5);

        // 4: manual_stop coincides with the final tick of a 1-unit run
        start = 1'b1; irrigation_time = 8'd1;
        watch(14, 3, 2, -1, 0);
        check_eq("t4_rem0", 32'(rem_log[0]), 1);
        check_eq("t4_abort_idx", 32'(abort_idx), 4);
        check_eq("t4_done_cnt", 32'(done_cnt), 0);
        check_eq("t4_pump_cycles", 32'(pump_cnt), 4);
        check_eq("t4_busy_cycles", 32'(busy_cnt), 12);
        check_eq("t4_total", 32'(total_units), 5);

        // 5: clamp to 200, restarts during WATERING and COOLDOWN ignored
        start = 1'b1; irrigation_time = 8'd250;
        watch(815, 10, 3, 803, 3);
        irrigation_time = 8'd0;
        check_eq("t5_rem0", 32'(rem_log[0]), 200);
        check_eq("t5_rem11", 32'(rem_log[11]), 198);
        check_eq("t5_pump_cycles", 32'(pump_cnt), 800);
        check_eq("t5_done_idx", 32'(done_idx), 800);
        check_eq("t5_done_cnt", 32'(done_cnt), 1);
        check_eq("t5_skip_cnt", 32'(skip_cnt), 0);
        check_eq("t5_busy_cycles", 32'(busy_cnt), 808);
        check_eq("t5_state_end", 32'(st_log[814]), 0);
        check_eq("t5_total", 32'(total_units), 205);

        // 6a: asynchronous reset mid-WATERING
        start = 1'b1; irrigation_time = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        check_eq("t6_pre_pump", 32'(pump_on), 1);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_pump", 32'(pump_on), 0);
        check_eq("t6_rst_busy", 32'(busy), 0);
        check_eq("t6_rst_state", 32'(state), 0);
        check_eq("t6_rst_rem", 32'(remaining), 0);
        check_eq("t6_rst_total", 32'(total_units), 0);
        check_eq("t6_rst_pulses", 32'({done, aborted, skipped}), 0);
        #10;
        reset = 1'b1;

        // 6b: saturation of total_units on the fast instance
        exp_tot = 0;
        @(posedge clk); #1;
        for (int r = 0; r < 330; r++) begin
            start_b = 1'b1; time_b = 8'd200;
            @(posedge clk); #1;
            start_b = 1'b0;
            pc = pump_on_b ? 1 : 0;
            got_end = 1'b0;
            for (int c = 0; c < 300 && !got_end; c++) begin
                @(posedge clk); #1;
                if (done_b || aborted_b) got_end = 1'b1;
                else if (pump_on_b) pc++;
            end
            check_eq("sat_run_end", 32'(got_end), 1);
            if (r == 0) begin
                check_eq("sat_pump_cycles", 32'(pc), 200);
                check_eq("sat_done", 32'(done_b), 1);
                check_eq("sat_busy_same_cycle", 32'(busy_b), 0);
                check_eq("sat_state_idle", 32'(state_b), 0);
            end
            exp_tot = (exp_tot + 200 > 65535) ? 65535 : exp_tot + 200;
            check_eq("sat_total", 32'(total_b), 32'(exp_tot));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
